// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory-access stage (req/ack data port, store strobes, load extension).
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
`timescale 1ns/1ps
`default_nettype none

module mem_stage_lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err,
  output logic            misaligned
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic [4:0]      rd_q;
  logic [CNT_W-1:0] cnt;
  logic            wb_we_q;
  logic [XLEN-1:0] wb_data_q;
  logic            bus_err_q;
  logic            mis_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load;
  logic            is_store;
  logic            accept;
  logic            mis;
  logic            timeout_hit;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic            unused_bits;

  assign opcode      = operation[6:0];
  assign funct3      = operation[9:7];
  assign unused_bits = ^operation[11:10];
  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  assign in_ready    = !reset && (state != S_REQ);
  assign accept      = in_valid && in_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   mis = 1'b0;
        2'b01:   mis = alu_result[0];
        default: mis = (alu_result[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign mis = 1'b0;
`endif

  // funct3[1:0] selects size for both loads and stores; unused encodings fall to word.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = mem_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (ld_f3)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= 4'b0000;
      ld_f3     <= 3'b000;
      ld_off    <= 2'b00;
      rd_q      <= 5'd0;
      cnt       <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (mem_ack) begin
            state     <= S_RESP;
            wb_we_q   <= !req_we && (rd_q != 5'd0);
            wb_data_q <= req_we ? '0 : ld_val;
          end else if (timeout_hit) begin
            state     <= S_RESP;
            bus_err_q <= 1'b1;
            wb_we_q   <= 1'b0;
            wb_data_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            rd_q      <= rd_addr;
            bus_err_q <= 1'b0;
            cnt       <= '0;
            if ((is_load || is_store) && !mis) begin
              state     <= S_REQ;
              mis_q     <= 1'b0;
              req_we    <= is_store;
              req_addr  <= {alu_result[XLEN-1:2], 2'b00};
              req_wdata <= is_store ? st_wdata : '0;
              req_wstrb <= is_store ? st_wstrb : 4'b0000;
              ld_f3     <= funct3;
              ld_off    <= alu_result[1:0];
              wb_we_q   <= 1'b0;
              wb_data_q <= '0;
            end else begin
              state     <= S_RESP;
              mis_q     <= mis;
              wb_we_q   <= !mis && (opcode != OP_BRANCH) && !is_store && (rd_addr != 5'd0);
              wb_data_q <= mis ? '0 : alu_result;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are qualified by state so nothing stale leaks outside REQ/RESP.
  assign mem_req    = (state == S_REQ);
  assign mem_we     = mem_req && req_we;
  assign mem_addr   = mem_req ? req_addr : '0;
  assign mem_wdata  = mem_req ? req_wdata : '0;
  assign mem_wstrb  = mem_req ? req_wstrb : 4'b0000;
  assign wb_valid   = (state == S_RESP);
  assign wb_we      = wb_valid && wb_we_q;
  assign wb_rd      = wb_valid ? rd_q : 5'd0;
  assign wb_data    = wb_valid ? wb_data_q : '0;
  assign bus_err    = wb_valid && bus_err_q;
  assign misaligned = wb_valid && mis_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed + randomized checks of mem_stage_lsu against a transaction-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage_lsu;

  localparam int TO = 16;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] operation;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err;
  logic        misaligned;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .alu_result(alu_result), .store_data(store_data),
    .rd_addr(rd_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus_err(bus_err), .misaligned(misaligned)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: size from funct3 low bits, lane arithmetic on the byte offset.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int off, input logic [31:0] d,
                           output logic [3:0] strb, output logic [31:0] wd);
    if (f3[1:0] == 2'd0) begin
      strb = 4'(1 << off);
      wd   = (d & 32'hFF) * 32'h0101_0101;
    end else if (f3[1:0] == 2'd1) begin
      strb = 4'(3 << (2 * (off / 2)));
      wd   = (d & 32'hFFFF) * 32'h0001_0001;
    end else begin
      strb = 4'hF;
      wd   = d;
    end
  endtask

  function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
    if (f3[1:0] == 2'd0) return 1'b0;
    if (f3[1:0] == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  // Called at a negedge with the stage in IDLE or RESP; returns at the negedge showing the writeback.
  task automatic do_op(input logic [6:0] op7, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input int delay,
                       input logic [31:0] rdat);
    bit is_ld, is_st, mis, go_mem, acked, e_err, e_we;
    int n, off;
    logic [31:0] e_data, ea, e_wd;
    logic [3:0]  e_strb;
    is_ld = (op7 == OPC_LOAD);
    is_st = (op7 == OPC_STORE);
    off   = int'(alu[1:0]);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (is_ld || is_st) && ref_misaligned(f3, off);
`endif
    go_mem = (is_ld || is_st) && !mis;
    in_valid   = 1'b1;
    operation  = {2'($urandom), f3, op7};
    alu_result = alu;
    store_data = sd;
    rd_addr    = rd;
    check_val("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    operation  = 12'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
    rd_addr    = 5'($urandom);
    e_err = 1'b0;
    acked = 1'b0;
    e_data = alu;
    e_we = !mis && op7 != OPC_BRANCH && op7 != OPC_STORE && rd != 5'd0;
    if (go_mem) begin
      ea = {alu[31:2], 2'b00};
      ref_store(f3, off, sd, e_strb, e_wd);
      if (is_ld) e_strb = 4'h0;
      n = 0;
      while (1) begin
        check_val("mem_req", {31'd0, mem_req}, 32'd1);
        check_val("mem_addr", mem_addr, ea);
        check_val("mem_we", {31'd0, mem_we}, {31'd0, is_st});
        check_val("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
        if (is_st) check_val("mem_wdata", mem_wdata, e_wd);
        check_val("in_ready_in_req", {31'd0, in_ready}, 32'd0);
        mem_ack   = (n == delay);
        mem_rdata = (n == delay) ? rdat : $urandom;
        @(negedge clk);
        n++;
        if (n - 1 == delay) begin
          acked = 1'b1;
          break;
        end
        if (n >= TO) break;
      end
      mem_ack = 1'b0;
      if (!acked) begin
        e_err = 1'b1;
        check_val("req_cycles", n, TO);
      end
      e_we   = !e_err && is_ld && rd != 5'd0;
      e_data = is_ld ? ref_load(f3, off, rdat) : 32'd0;
    end
    check_val("wb_valid", {31'd0, wb_valid}, 32'd1);
    check_val("wb_we", {31'd0, wb_we}, {31'd0, e_we});
    check_val("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    if (!e_err && !mis) check_val("wb_data", wb_data, e_data);
    check_val("bus_err", {31'd0, bus_err}, {31'd0, e_err});
    check_val("misaligned", {31'd0, misaligned}, {31'd0, mis});
    check_val("mem_req_in_resp", {31'd0, mem_req}, 32'd0);
  endtask

  // Idle cycles with stray acks, which the stage must ignore.
  task automatic idle(input int k);
    repeat (k) begin
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      check_val("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
      check_val("idle_mem_req", {31'd0, mem_req}, 32'd0);
      check_val("idle_in_ready", {31'd0, in_ready}, 32'd1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] op7;
    int sel, dly;
    reset = 1'b1; in_valid = 1'b0; operation = '0; alu_result = '0;
    store_data = '0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    idle(2);

    do_op(OPC_IMM, 3'd0, 32'h0000_0005, 32'd0, 5'd3, 0, 32'd0);
    idle(1);
    do_op(OPC_LOAD, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h8000_0000);
    do_op(OPC_LOAD, 3'd4, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h8000_0000);
    do_op(OPC_STORE, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 5'd1, 3, 32'd0);
    idle(1);
    do_op(OPC_LOAD, 3'd2, 32'h0000_0040, 32'd0, 5'd9, -1, 32'd0);
    do_op(OPC_LOAD, 3'd2, 32'h0000_0044, 32'd0, 5'd9, TO - 1, 32'hCAFE_F00D);
    do_op(OPC_LOAD, 3'd2, 32'h0000_0006, 32'd0, 5'd4, 1, 32'h0BAD_BEEF);
    do_op(OPC_STORE, 3'd2, 32'h0000_0011, 32'hA5A5_5A5A, 5'd0, 0, 32'd0);
    do_op(OPC_BRANCH, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0);

    // Asynchronous reset in the middle of a request.
    idle(1);
    in_valid = 1'b1; operation = {5'd0, OPC_LOAD}; operation[9:7] = 3'd2;
    alu_result = 32'h0000_0080; rd_addr = 5'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("async_rst_mem_addr", mem_addr, 32'd0);
    check_val("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    do_op(OPC_IMM, 3'd0, 32'h0000_0021, 32'd0, 5'd8, 0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2: op7 = OPC_LOAD;
        3, 4:    op7 = OPC_STORE;
        5:       op7 = OPC_BRANCH;
        6:       op7 = OPC_IMM;
        default: op7 = 7'($urandom);
      endcase
      if ($urandom_range(0, 11) == 0)      dly = -1;
      else if ($urandom_range(0, 15) == 0) dly = TO - 1;
      else                                 dly = $urandom_range(0, 4);
      do_op(op7, 3'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), dly, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
